// File: rtl/exc_pkg.sv
// Shared types and constants for the exception controller.
// Optional build macro EXC_CNT_EN (used in exception_ctrl) adds an entry counter.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    HANDLER = 2'd2,
    RETURN  = 2'd3
  } state_t;

  localparam logic [3:0] ESR_NONE   = 4'b0000;
  localparam logic [3:0] ESR_IRQ    = 4'b0001;
  localparam logic [3:0] ESR_UNDEF  = 4'b0010;
  localparam logic [3:0] ESR_DFAULT = 4'b1111;

  localparam logic [63:0] DEF_VECTOR_ADDR = 64'h0000_0000_0000_00D8;

endpackage

// File: rtl/exc_cause_enc.sv
// Priority encoder deciding whether an exception entry is taken this cycle
// and with which syndrome. ERet overrides NotAnInstr because the decoder
// raises both for ERET; a synchronous fault outranks the external IRQ.
module exc_cause_enc
  import exc_pkg::*;
(
  input  logic       ExtIRQ,
  input  logic       NotAnInstr,
  input  logic       ERet,
  input  state_t     state,
  output logic       take,
  output logic [3:0] cause
);

  logic undef;

  assign undef = NotAnInstr & ~ERet;

  // Select entry cause by state; ENTRY and RETURN never take a new exception.
  always_comb begin
    take  = 1'b0;
    cause = ESR_NONE;
    unique case (state)
      IDLE: begin
        if (ERet || undef) begin
          take  = 1'b1;
          cause = ESR_UNDEF;
        end else if (ExtIRQ) begin
          take  = 1'b1;
          cause = ESR_IRQ;
        end
      end
      HANDLER: begin
        if (undef) begin
          take  = 1'b1;
          cause = ESR_DFAULT;
        end
      end
      default: begin
        take  = 1'b0;
        cause = ESR_NONE;
      end
    endcase
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception entry/return sequencer beside the LEGv8 decoder, feeding the PC mux.
// Build option: define EXC_CNT_EN to add the saturating ExcCount output.
//
// state   | meaning
// IDLE    | normal execution, watching for fault/ERET/IRQ
// ENTRY   | one cycle: acknowledge and redirect fetch to the handler vector
// HANDLER | handler running, IRQ masked, waiting for ERET or double fault
// RETURN  | one cycle: redirect fetch back to ELR
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned          PC_W        = 64,
  parameter logic [PC_W-1:0]      VECTOR_ADDR = PC_W'(DEF_VECTOR_ADDR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ExtIRQ,
  input  logic            NotAnInstr,
  input  logic            ERet,
  input  logic [PC_W-1:0] InstrPC,
  output logic            ExcAck,
  output logic            ExtIAck,
  output logic            Redirect,
  output logic [PC_W-1:0] RedirectPC,
  output logic [PC_W-1:0] ELR,
  output logic [3:0]      ESR,
`ifdef EXC_CNT_EN
  output logic [15:0]     ExcCount,
`endif
  output logic            InHandler
);

  state_t     state, state_nxt;
  logic       take;
  logic [3:0] cause;
  logic       cap_elr;
  logic       cap_esr;

  exc_cause_enc u_cause_enc (
    .ExtIRQ     (ExtIRQ),
    .NotAnInstr (NotAnInstr),
    .ERet       (ERet),
    .state      (state),
    .take       (take),
    .cause      (cause)
  );

  // Next-state and register-capture decisions.
  always_comb begin
    state_nxt = state;
    cap_elr   = 1'b0;
    cap_esr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (take) begin
          state_nxt = ENTRY;
          cap_elr   = 1'b1;
          cap_esr   = 1'b1;
        end
      end
      ENTRY: begin
        state_nxt = HANDLER;
      end
      HANDLER: begin
        if (ERet) begin
          state_nxt = RETURN;
        end else if (take) begin
          // Double fault keeps ELR so the original return point survives.
          state_nxt = ENTRY;
          cap_esr   = 1'b1;
        end
      end
      RETURN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register plus exception context; reset discards everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ELR   <= '0;
      ESR   <= ESR_NONE;
    end else begin
      state <= state_nxt;
      if (cap_elr) ELR <= InstrPC;
      if (cap_esr) ESR <= cause;
    end
  end

  // Moore output decodes of registered state only.
  always_comb begin
    ExcAck     = 1'b0;
    ExtIAck    = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = '0;
    InHandler  = 1'b0;
    unique case (state)
      ENTRY: begin
        ExcAck     = 1'b1;
        ExtIAck    = (ESR == ESR_IRQ);
        Redirect   = 1'b1;
        RedirectPC = VECTOR_ADDR;
      end
      HANDLER: begin
        InHandler = 1'b1;
      end
      RETURN: begin
        Redirect   = 1'b1;
        RedirectPC = ELR;
      end
      default: begin
        ExcAck = 1'b0;
      end
    endcase
  end

`ifdef EXC_CNT_EN
  // Count entry cycles, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ExcCount <= '0;
    end else if (state == ENTRY && ExcCount != 16'hFFFF) begin
      ExcCount <= ExcCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed testbench for exception_ctrl.
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ExtIRQ;
  logic        NotAnInstr;
  logic        ERet;
  logic [63:0] InstrPC;
  logic        ExcAck;
  logic        ExtIAck;
  logic        Redirect;
  logic [63:0] RedirectPC;
  logic [63:0] ELR;
  logic [3:0]  ESR;
  logic        InHandler;
`ifdef EXC_CNT_EN
  logic [15:0] ExcCount;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] VEC = 64'hD8;

  exception_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .ExtIRQ     (ExtIRQ),
    .NotAnInstr (NotAnInstr),
    .ERet       (ERet),
    .InstrPC    (InstrPC),
    .ExcAck     (ExcAck),
    .ExtIAck    (ExtIAck),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .ELR        (ELR),
    .ESR        (ESR),
`ifdef EXC_CNT_EN
    .ExcCount   (ExcCount),
`endif
    .InHandler  (InHandler)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ExtIRQ = 1'b0; NotAnInstr = 1'b0; ERet = 1'b0;
  endtask

  // Issue ERET from HANDLER and return to IDLE, checking the return target.
  task automatic do_eret(input logic [63:0] ret_pc, input string name);
    ERet = 1'b1; NotAnInstr = 1'b1;
    step();
    checks++;
    if (Redirect !== 1'b1 || RedirectPC !== ret_pc || InHandler !== 1'b0 || ExcAck !== 1'b0) begin
      errors++;
      $display("FAIL %s_return: Redirect=%0b RedirectPC=%0h InHandler=%0b ExcAck=%0b want 1 %0h 0 0",
               name, Redirect, RedirectPC, InHandler, ExcAck, ret_pc);
    end
    ERet = 1'b0; NotAnInstr = 1'b0;
  endtask

  task automatic test_reset();
    clear_in(); InstrPC = '0;
    reset = 1'b1;
    step(); step();
    checks++;
    if ({ExcAck, ExtIAck, Redirect, InHandler} !== 4'b0 || RedirectPC !== 64'h0 ||
        ELR !== 64'h0 || ESR !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: ack=%0b iack=%0b redir=%0b inh=%0b rpc=%0h elr=%0h esr=%0h want all 0",
               ExcAck, ExtIAck, Redirect, InHandler, RedirectPC, ELR, ESR);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_undef();
    NotAnInstr = 1'b1; InstrPC = 64'h40;
    step();
    checks++;
    if (ExcAck !== 1'b1 || Redirect !== 1'b1 || RedirectPC !== VEC || ESR !== 4'b0010 ||
        ELR !== 64'h40 || ExtIAck !== 1'b0) begin
      errors++;
      $display("FAIL undef_entry: ack=%0b redir=%0b rpc=%0h esr=%0h elr=%0h iack=%0b want 1 1 d8 2 40 0",
               ExcAck, Redirect, RedirectPC, ESR, ELR, ExtIAck);
    end
    clear_in();
    step();
    checks++;
    if (InHandler !== 1'b1 || ExcAck !== 1'b0 || Redirect !== 1'b0) begin
      errors++;
      $display("FAIL undef_handler: inh=%0b ack=%0b redir=%0b want 1 0 0", InHandler, ExcAck, Redirect);
    end
    do_eret(64'h40, "undef");
    step();
    checks++;
    if (Redirect !== 1'b0 || InHandler !== 1'b0 || ESR !== 4'b0010) begin
      errors++;
      $display("FAIL undef_idle: redir=%0b inh=%0b esr=%0h want 0 0 2", Redirect, InHandler, ESR);
    end
  endtask

  task automatic test_irq_vs_fault();
    ExtIRQ = 1'b1; NotAnInstr = 1'b1; InstrPC = 64'h10;
    step();
    checks++;
    if (ESR !== 4'b0010 || ExtIAck !== 1'b0 || ExcAck !== 1'b1 || ELR !== 64'h10) begin
      errors++;
      $display("FAIL prio_entry: esr=%0h iack=%0b ack=%0b elr=%0h want 2 0 1 10", ESR, ExtIAck, ExcAck, ELR);
    end
    NotAnInstr = 1'b0;
    step();
    checks++;
    if (InHandler !== 1'b1 || ExcAck !== 1'b0) begin
      errors++;
      $display("FAIL prio_masked: inh=%0b ack=%0b want 1 0", InHandler, ExcAck);
    end
    do_eret(64'h10, "prio");
    InstrPC = 64'h14;
    step();
    checks++;
    if (ExcAck !== 1'b0 || Redirect !== 1'b0) begin
      errors++;
      $display("FAIL prio_idle: ack=%0b redir=%0b want 0 0", ExcAck, Redirect);
    end
    step();
    checks++;
    if (ExcAck !== 1'b1 || ExtIAck !== 1'b1 || ESR !== 4'b0001 || ELR !== 64'h14 || RedirectPC !== VEC) begin
      errors++;
      $display("FAIL prio_irq_reentry: ack=%0b iack=%0b esr=%0h elr=%0h rpc=%0h want 1 1 1 14 d8",
               ExcAck, ExtIAck, ESR, ELR, RedirectPC);
    end
    ExtIRQ = 1'b0;
    step();
    do_eret(64'h14, "prio_irq");
    step();
  endtask

  task automatic test_masking();
    ExtIRQ = 1'b1; InstrPC = 64'h80;
    step();
    checks++;
    if (ExcAck !== 1'b1 || ExtIAck !== 1'b1 || ESR !== 4'b0001 || ELR !== 64'h80) begin
      errors++;
      $display("FAIL mask_entry: ack=%0b iack=%0b esr=%0h elr=%0h want 1 1 1 80", ExcAck, ExtIAck, ESR, ELR);
    end
    ExtIRQ = 1'b0;
    step();
    ExtIRQ = 1'b1; InstrPC = 64'h90;
    step();
    checks++;
    if (ExcAck !== 1'b0 || ExtIAck !== 1'b0 || InHandler !== 1'b1 || ELR !== 64'h80) begin
      errors++;
      $display("FAIL mask_pulse: ack=%0b iack=%0b inh=%0b elr=%0h want 0 0 1 80", ExcAck, ExtIAck, InHandler, ELR);
    end
    ExtIRQ = 1'b0;
    do_eret(64'h80, "mask");
    step();
  endtask

  task automatic test_eret_outside();
    ERet = 1'b1; NotAnInstr = 1'b1; InstrPC = 64'h24;
    step();
    checks++;
    if (ExcAck !== 1'b1 || ESR !== 4'b0010 || ELR !== 64'h24 || RedirectPC !== VEC || ExtIAck !== 1'b0) begin
      errors++;
      $display("FAIL eret_outside: ack=%0b esr=%0h elr=%0h rpc=%0h iack=%0b want 1 2 24 d8 0",
               ExcAck, ESR, ELR, RedirectPC, ExtIAck);
    end
    clear_in();
    step();
    do_eret(64'h24, "eret_outside");
    step();
  endtask

  task automatic test_double_fault();
    NotAnInstr = 1'b1; InstrPC = 64'h30;
    step();
    clear_in();
    step();
    NotAnInstr = 1'b1; InstrPC = 64'hE0;
    step();
    checks++;
    if (ExcAck !== 1'b1 || ESR !== 4'b1111 || ELR !== 64'h30 || RedirectPC !== VEC ||
        ExtIAck !== 1'b0 || InHandler !== 1'b0) begin
      errors++;
      $display("FAIL double_fault: ack=%0b esr=%0h elr=%0h rpc=%0h iack=%0b inh=%0b want 1 f 30 d8 0 0",
               ExcAck, ESR, ELR, RedirectPC, ExtIAck, InHandler);
    end
    clear_in();
    step();
    checks++;
    if (InHandler !== 1'b1 || ESR !== 4'b1111 || ELR !== 64'h30) begin
      errors++;
      $display("FAIL double_fault_handler: inh=%0b esr=%0h elr=%0h want 1 f 30", InHandler, ESR, ELR);
    end
`ifdef EXC_CNT_EN
    checks++;
    if (ExcCount !== 16'd7) begin
      errors++;
      $display("FAIL exc_count: got %0d want 7", ExcCount);
    end
`endif
  endtask

  task automatic test_reset_mid_handler();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({ExcAck, ExtIAck, Redirect, InHandler} !== 4'b0 || RedirectPC !== 64'h0 ||
        ELR !== 64'h0 || ESR !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_handler: ack=%0b iack=%0b redir=%0b inh=%0b rpc=%0h elr=%0h esr=%0h want all 0",
               ExcAck, ExtIAck, Redirect, InHandler, RedirectPC, ELR, ESR);
    end
`ifdef EXC_CNT_EN
    checks++;
    if (ExcCount !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", ExcCount);
    end
`endif
    step();
    reset = 1'b0;
    step();
    checks++;
    if (InHandler !== 1'b0 || ExcAck !== 1'b0 || Redirect !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: inh=%0b ack=%0b redir=%0b want 0 0 0", InHandler, ExcAck, Redirect);
    end
  endtask

  initial begin
    test_reset();
    test_undef();
    test_irq_vs_fault();
    test_masking();
    test_eret_outside();
    test_double_fault();
    test_reset_mid_handler();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
